// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch fill datapath: sequencer state
// encoding, index-counter command set, symbol width and default length.
package nw_pkg;

    localparam int NW_SYM_W     = 3;
    localparam int NW_N_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_ROW,
        ST_INIT_COL,
        ST_ADDR,
        ST_READ,
        ST_CMP,
        ST_CELL,
        ST_DONE
    } nw_sched_state_t;

    // Commands the sequencer issues to the nested i/j counter.
    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_CLR,         // i = j = 0
        CNT_INC_J,       // walk along row 0
        CNT_INC_I,       // walk down column 0
        CNT_FIRST_COL,   // i = 1, j = 0
        CNT_FIRST_CELL,  // i = j = 1
        CNT_STEP         // row-major step over the inner cells
    } nw_cnt_cmd_t;

    // Sequence-RAM address width; a one-symbol sequence still needs one bit.
    function automatic int nw_addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nw_index_counter.sv
// Nested i/j matrix index counter. The sequencer drives it through both the
// boundary-initialisation walk and the row-major inner-cell walk.
module nw_index_counter
    import nw_pkg::*;
#(
    parameter int N  = NW_N_DEFAULT,
    parameter int CW = $clog2(N + 1)
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  nw_cnt_cmd_t   i_cmd,
    output logic [CW-1:0] o_i,
    output logic [CW-1:0] o_j,
    output logic          o_wrap_j,
    output logic          o_last_i,
    output logic          o_last
);

    localparam logic [CW-1:0] C_N   = CW'(N);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;

    // Index update; values never exceed N because the sequencer only steps
    // while the relevant index is still below N.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i <= '0;
            r_j <= '0;
        end else begin
            case (i_cmd)
                CNT_CLR: begin
                    r_i <= '0;
                    r_j <= '0;
                end
                CNT_INC_J:      r_j <= r_j + C_ONE;
                CNT_INC_I:      r_i <= r_i + C_ONE;
                CNT_FIRST_COL: begin
                    r_i <= C_ONE;
                    r_j <= '0;
                end
                CNT_FIRST_CELL: begin
                    r_i <= C_ONE;
                    r_j <= C_ONE;
                end
                CNT_STEP: begin
                    if (r_j == C_N) begin
                        r_j <= C_ONE;
                        r_i <= r_i + C_ONE;
                    end else begin
                        r_j <= r_j + C_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_i      = r_i;
    assign o_j      = r_j;
    assign o_wrap_j = (r_j == C_N);
    assign o_last_i = (r_i == C_N);
    assign o_last   = (r_i == C_N) && (r_j == C_N);

endmodule

// File: rtl/nw_fill_scheduler.sv
// Needleman-Wunsch score-matrix fill sequencer: boundary writes for row 0 and
// column 0, then one strictly serialised inner cell at a time (address, read,
// compare, hand-off to the cell unit over req/ack).
// Optional build macro: NW_SCHED_PERF_EN adds the o_perf_cycles busy counter.
module nw_fill_scheduler
    import nw_pkg::*;
#(
    parameter int N  = NW_N_DEFAULT,
    parameter int AW = nw_addr_width(N),
    parameter int CW = $clog2(N + 1)
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_addr_a,
    output logic [AW-1:0] o_addr_b,
    output logic          o_en_read,
    input  logic          i_match,
    output logic          o_init_we,
    output logic [CW-1:0] o_cell_i,
    output logic [CW-1:0] o_cell_j,
    output logic          o_cell_req,
    output logic          o_cell_match,
    input  logic          i_cell_ack
`ifdef NW_SCHED_PERF_EN
    ,
    output logic [31:0]   o_perf_cycles
`endif
);

    localparam logic [CW-1:0] C_ONE = CW'(1);

    nw_sched_state_t r_state;
    nw_sched_state_t w_state_next;
    nw_cnt_cmd_t     w_cnt_cmd;

    logic [CW-1:0] w_i;
    logic [CW-1:0] w_j;
    logic          w_wrap_j;
    logic          w_last_i;
    logic          w_last;

    logic [AW-1:0] r_addr_a;
    logic [AW-1:0] r_addr_b;
    logic          r_cell_match;

    nw_index_counter #(
        .N  (N),
        .CW (CW)
    ) u_index (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_cmd    (w_cnt_cmd),
        .o_i      (w_i),
        .o_j      (w_j),
        .o_wrap_j (w_wrap_j),
        .o_last_i (w_last_i),
        .o_last   (w_last)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, counter command and state-decoded strobes.
    always_comb begin
        w_state_next = r_state;
        w_cnt_cmd    = CNT_HOLD;
        o_busy       = (r_state != ST_IDLE);
        o_done       = 1'b0;
        o_init_we    = 1'b0;
        o_en_read    = 1'b0;
        o_cell_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_cnt_cmd    = CNT_CLR;
                    w_state_next = ST_INIT_ROW;
                end
            end
            ST_INIT_ROW: begin
                o_init_we = 1'b1;
                if (w_wrap_j) begin
                    w_cnt_cmd    = CNT_FIRST_COL;
                    w_state_next = ST_INIT_COL;
                end else begin
                    w_cnt_cmd = CNT_INC_J;
                end
            end
            ST_INIT_COL: begin
                o_init_we = 1'b1;
                if (w_last_i) begin
                    w_cnt_cmd    = CNT_FIRST_CELL;
                    w_state_next = ST_ADDR;
                end else begin
                    w_cnt_cmd = CNT_INC_I;
                end
            end
            ST_ADDR: begin
                w_state_next = ST_READ;
            end
            ST_READ: begin
                o_en_read    = 1'b1;
                w_state_next = ST_CMP;
            end
            ST_CMP: begin
                w_state_next = ST_CELL;
            end
            ST_CELL: begin
                o_cell_req = 1'b1;
                if (i_cell_ack) begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_cnt_cmd    = CNT_STEP;
                        w_state_next = ST_ADDR;
                    end
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Sequence-RAM addresses are captured in ADDR; the comparator result is
    // captured at the end of CMP and held through the whole CELL hand-off.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_cell_match <= 1'b0;
        end else begin
            if (r_state == ST_ADDR) begin
                r_addr_a <= AW'(w_i - C_ONE);
                r_addr_b <= AW'(w_j - C_ONE);
            end
            if (r_state == ST_CMP) begin
                r_cell_match <= i_match;
            end
        end
    end

    assign o_addr_a     = r_addr_a;
    assign o_addr_b     = r_addr_b;
    assign o_cell_match = r_cell_match;
    assign o_cell_i     = w_i;
    assign o_cell_j     = w_j;

`ifdef NW_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;

    // Busy-cycle counter: cleared on an accepted start, saturating, held in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_cycles <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_perf_cycles <= '0;
            end
        end else if (r_perf_cycles != 32'hFFFF_FFFF) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign o_perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_nw_fill_scheduler.sv
// Self-checking bench for nw_fill_scheduler (N=4). A queue-based model lists
// the boundary writes and inner cells the fill must produce; one monitor
// compares the DUT against it every cycle. Build with NW_SCHED_PERF_EN to
// also check o_perf_cycles.
module tb_nw_fill_scheduler;

    localparam int TN  = 4;
    localparam int TAW = 2;
    localparam int TCW = 3;

    typedef struct {
        int i;
        int j;
    } coord_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           match;
    logic           ack;
    logic           busy;
    logic           done;
    logic [TAW-1:0] addr_a;
    logic [TAW-1:0] addr_b;
    logic           en_read;
    logic           init_we;
    logic [TCW-1:0] cell_i;
    logic [TCW-1:0] cell_j;
    logic           cell_req;
    logic           cell_match;
`ifdef NW_SCHED_PERF_EN
    logic [31:0]    perf;
`endif

    nw_fill_scheduler #(.N(TN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_addr_a     (addr_a),
        .o_addr_b     (addr_b),
        .o_en_read    (en_read),
        .i_match      (match),
        .o_init_we    (init_we),
        .o_cell_i     (cell_i),
        .o_cell_j     (cell_j),
        .o_cell_req   (cell_req),
        .o_cell_match (cell_match),
        .i_cell_ack   (ack)
`ifdef NW_SCHED_PERF_EN
        ,
        .o_perf_cycles(perf)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state shared by the driver and the monitor.
    coord_t exp_init[$];
    coord_t exp_cell[$];
    int     seq_a[TN];
    int     seq_b[TN];
    int     dly_i = 0, dly_j = 0, dly_len = 0;
    int     exp_busy_len = 0;
    int     done_cnt = 0;
    int     last_busy_len = 0;
    int     obs_match[TN+1][TN+1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_match(input int i, input int j);
        return (seq_a[i-1] == seq_b[j-1]) ? 1 : 0;
    endfunction

    // Monitor: compares every cycle against the expected event queues.
    initial begin
        int     prev_busy = 0;
        int     prev_req  = 0;
        int     busy_cnt  = 0;
        int     req_cnt   = 0;
        coord_t cur;
        coord_t c;
        cur.i = 0;
        cur.j = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_busy = 0;
                prev_req  = 0;
                busy_cnt  = 0;
                req_cnt   = 0;
                continue;
            end
            chk("strobe_outside_busy", 32'((init_we | en_read | cell_req | done) & ~busy), 0);
            chk("strobe_onehot", 32'(int'(init_we) + int'(en_read) + int'(cell_req) + int'(done) > 1), 0);
            if (init_we) begin
                if (exp_init.size() == 0) begin
                    chk("init_extra", 1, 0);
                end else begin
                    c = exp_init.pop_front();
                    chk("init_i", 32'(cell_i), c.i);
                    chk("init_j", 32'(cell_j), c.j);
                    $display("init write (%0d,%0d)", cell_i, cell_j);
                end
            end
            if (en_read) begin
                if (exp_cell.size() == 0) begin
                    chk("read_extra", 1, 0);
                end else begin
                    c = exp_cell[0];
                    chk("addr_a", 32'(addr_a), c.i - 1);
                    chk("addr_b", 32'(addr_b), c.j - 1);
                end
            end
            if (cell_req) begin
                if (!prev_req) begin
                    if (exp_cell.size() == 0) begin
                        chk("cell_extra", 1, 0);
                    end else begin
                        cur = exp_cell.pop_front();
                        chk("cell_i", 32'(cell_i), cur.i);
                        chk("cell_j", 32'(cell_j), cur.j);
                        chk("cell_match", 32'(cell_match), exp_match(cur.i, cur.j));
                        obs_match[cur.i][cur.j] = int'(cell_match);
                        $display("cell (%0d,%0d) match=%0d", cell_i, cell_j, cell_match);
                    end
                    req_cnt = 1;
                end else begin
                    chk("hold_i", 32'(cell_i), cur.i);
                    chk("hold_j", 32'(cell_j), cur.j);
                    chk("hold_match", 32'(cell_match), exp_match(cur.i, cur.j));
                    req_cnt++;
                end
            end else if (prev_req) begin
                chk("cell_residency", req_cnt,
                    (cur.i == dly_i && cur.j == dly_j) ? dly_len + 1 : 1);
            end
            if (done) begin
                done_cnt++;
                chk("done_queues_empty", exp_init.size() + exp_cell.size(), 0);
                $display("done pulse after %0d busy cycles", busy_cnt + 1);
            end
            if (busy) begin
                if (!prev_busy) begin
                    busy_cnt = 0;
`ifdef NW_SCHED_PERF_EN
                    chk("perf_cleared", perf, 0);
`endif
                end
                busy_cnt++;
            end else if (prev_busy) begin
                last_busy_len = busy_cnt;
                chk("busy_len", busy_cnt, exp_busy_len);
`ifdef NW_SCHED_PERF_EN
                chk("perf_after_done", perf, busy_cnt);
`endif
            end
            prev_busy = int'(busy);
            prev_req  = int'(cell_req);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_done"},     32'(done), 0);
        chk({tag, "_addr_a"},   32'(addr_a), 0);
        chk({tag, "_addr_b"},   32'(addr_b), 0);
        chk({tag, "_en_read"},  32'(en_read), 0);
        chk({tag, "_init_we"},  32'(init_we), 0);
        chk({tag, "_cell_i"},   32'(cell_i), 0);
        chk({tag, "_cell_j"},   32'(cell_j), 0);
        chk({tag, "_cell_req"}, 32'(cell_req), 0);
        chk({tag, "_match"},    32'(cell_match), 0);
`ifdef NW_SCHED_PERF_EN
        chk({tag, "_perf"},     perf, 0);
`endif
    endtask

    // One fill: load the model, pulse start, then drive the RAM comparator,
    // ack and (optionally) noise every cycle until the sequencer goes idle.
    task automatic run_fill(input int noise, input int rst_at_31,
                            input int d_i, input int d_j, input int d_len);
        coord_t c;
        int dcnt   = 0;
        int cyc    = 0;
        int en_prev = 0;
        int ra     = 0;
        int rb     = 0;
        int ended  = 0;
        dly_i = d_i;
        dly_j = d_j;
        dly_len = d_len;
        exp_busy_len = (TN + 1) + TN + 4 * TN * TN + 1 + d_len;
        exp_init.delete();
        exp_cell.delete();
        for (int j = 0; j <= TN; j++) begin c.i = 0; c.j = j; exp_init.push_back(c); end
        for (int i = 1; i <= TN; i++) begin c.i = i; c.j = 0; exp_init.push_back(c); end
        for (int i = 1; i <= TN; i++)
            for (int j = 1; j <= TN; j++) begin c.i = i; c.j = j; exp_cell.push_back(c); end
        done_cnt = 0;
        last_busy_len = 0;
        @(negedge clk);
        start = 1'b1;
        while (ended == 0) begin
            @(negedge clk);
            cyc++;
            if (noise != 0)
                start = done ? 1'b1 : (busy ? 1'($urandom_range(0, 1)) : 1'b0);
            else
                start = 1'b0;
            if (en_read) begin
                ra = int'(addr_a);
                rb = int'(addr_b);
            end
            if (en_read || en_prev != 0)
                match = (seq_a[ra] == seq_b[rb]);
            else
                match = 1'($urandom_range(0, 1));
            en_prev = int'(en_read);
            if (cell_req) begin
                if (int'(cell_i) == d_i && int'(cell_j) == d_j && dcnt < d_len) begin
                    ack = 1'b0;
                    dcnt++;
                end else begin
                    ack = 1'b1;
                end
            end else begin
                ack = (noise != 0) ? (en_read ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
            end
            if (rst_at_31 != 0 && cell_req && cell_i == 3'd3 && cell_j == 3'd1) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("async_rst");
                @(negedge clk);
                @(negedge clk);
                check_all_zero("rst_hold");
                #2 rst_n = 1'b1;
                chk("rst_no_done", done_cnt, 0);
                ended = 1;
            end else if (!busy) begin
                ended = 1;
            end
            if (cyc > 2000) begin
                chk("run_timeout", cyc, 2000);
                ended = 1;
            end
        end
        start = 1'b0;
        ack   = 1'b0;
        // Sequencer must stay idle afterwards (start in DONE was ignored).
        if (rst_at_31 == 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("idle_after_run", 32'(busy), 0);
            end
            chk("run_done_once", done_cnt, 1);
            chk("run_cells_left", exp_cell.size(), 0);
            chk("run_inits_left", exp_init.size(), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        match = 1'b0;
        ack   = 1'b0;
        for (int k = 0; k < TN; k++) begin
            seq_a[k] = k + 1;
            seq_b[k] = k + 1;
        end
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Ack tied high, match on the diagonal.
        run_fill(0, 0, 0, 0, 0);
        chk("lit_busy_74", last_busy_len, 74);
        chk("lit_match_11", obs_match[1][1], 1);
        chk("lit_match_23", obs_match[2][3], 0);
        chk("lit_match_32", obs_match[3][2], 0);
        chk("lit_match_44", obs_match[4][4], 1);

        // Ack held low for 3 cycles at (2,3).
        run_fill(0, 0, 2, 3, 3);
        chk("lit_busy_77", last_busy_len, 77);

        // Reset during CELL at (3,1), then a fresh fill from (0,0).
        run_fill(0, 1, 0, 0, 0);
        run_fill(0, 0, 0, 0, 0);
        chk("lit_busy_after_rst", last_busy_len, 74);

        // Different sequence B with start/ack noise outside their windows.
        seq_b[0] = 2; seq_b[1] = 2; seq_b[2] = 5; seq_b[3] = 1;
        run_fill(1, 0, 0, 0, 0);
        chk("lit_noise_busy", last_busy_len, 74);
        chk("lit_match2_21", obs_match[2][1], 1);
        chk("lit_match2_22", obs_match[2][2], 1);
        chk("lit_match2_14", obs_match[1][4], 1);
        chk("lit_match2_11", obs_match[1][1], 0);
        chk("lit_match2_33", obs_match[3][3], 0);

        // Back-to-back fill with noise and a delayed ack.
        run_fill(1, 0, 4, 2, 2);
        chk("lit_busy_76", last_busy_len, 76);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
